// File: rtl/mary_ask_modulator.sv
// M-ary ASK transmitter: packs 1-3 serial bits per symbol and amplitude-keys a
// phase-accumulator carrier read from an external, one-cycle-latency sine LUT.
module mary_ask_modulator #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int DATA_W  = 8,
  parameter int SYM_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_bps,
  input  logic [PHASE_W-1:0] cfg_fcw,
  input  logic [SYM_W-1:0]   cfg_sym_period,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sym_strobe,
  output logic               underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Level step per mode keeps the top symbol at or just below full scale.
  function automatic logic [7:0] amp_of(input logic [1:0] bps, input logic [2:0] sym);
    logic [10:0] prod;
    case (bps)
      2'd1:    prod = {8'd0, sym} * 11'd255;
      2'd2:    prod = {8'd0, sym} * 11'd85;
      2'd3:    prod = {8'd0, sym} * 11'd36;
      default: prod = '0;
    endcase
    return prod[7:0];
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s, input logic [7:0] a);
    logic [DATA_W+7:0] prod;
    prod = {8'd0, s} * {{DATA_W{1'b0}}, a};
    return prod[DATA_W+7:8];
  endfunction

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [1:0]         bps_act_q, bps_act_d;
  logic [1:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         buf_q, buf_d;
  logic [2:0]         symbol_q, symbol_d;
  logic               sym_strobe_q, sym_strobe_d;
  logic               underrun_q, underrun_d;
  logic [7:0]         amp_p1_q, amp_p1_d;
  logic [DATA_W-1:0]  sample_p2_q, sample_p2_d;

  logic               tick;
  logic               hs;
  logic [2:0]         buf_acc;
  logic [1:0]         cnt_acc;
  logic               complete;

  assign bit_ready = (state_q == FILL);
  assign tick      = (sym_cnt_q == cfg_sym_period);
  assign hs        = bit_valid & bit_ready;
  assign buf_acc   = hs ? {buf_q[1:0], bit_in} : buf_q;
  assign cnt_acc   = bit_cnt_q + {1'b0, hs};
  assign complete  = (bps_act_q != 2'd0) && (cnt_acc == bps_act_q);

  always_comb begin
    phase_d      = phase_q + cfg_fcw;
    sym_cnt_d    = tick ? '0 : sym_cnt_q + SYM_W'(1);
    bps_act_d    = bps_act_q;
    bit_cnt_d    = cnt_acc;
    buf_d        = buf_acc;
    symbol_d     = symbol_q;
    sym_strobe_d = tick;
    underrun_d   = 1'b0;
    state_d      = state_q;

    if (!tick) begin
      if (bps_act_q == 2'd0) state_d = IDLE;
      else                   state_d = complete ? FULL : FILL;
    end else if (cfg_bps != bps_act_q) begin
      // Mode change wins over everything: the half-built buffer is meaningless now.
      bps_act_d = cfg_bps;
      bit_cnt_d = '0;
      buf_d     = '0;
      symbol_d  = '0;
      state_d   = (cfg_bps == 2'd0) ? IDLE : FILL;
    end else if (complete) begin
      symbol_d  = buf_acc;
      bit_cnt_d = '0;
      buf_d     = '0;
      state_d   = FILL;
    end else if (bps_act_q != 2'd0) begin
      symbol_d   = '0;
      underrun_d = 1'b1;
      state_d    = FILL;
    end else begin
      symbol_d = '0;
      state_d  = IDLE;
    end

    amp_p1_d    = amp_of(bps_act_q, symbol_q);
    sample_p2_d = scale(lut_data, amp_p1_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      sym_cnt_q    <= '0;
      bps_act_q    <= '0;
      bit_cnt_q    <= '0;
      buf_q        <= '0;
      symbol_q     <= '0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      amp_p1_q     <= '0;
      sample_p2_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sym_cnt_q    <= sym_cnt_d;
      bps_act_q    <= bps_act_d;
      bit_cnt_q    <= bit_cnt_d;
      buf_q        <= buf_d;
      symbol_q     <= symbol_d;
      sym_strobe_q <= sym_strobe_d;
      underrun_q   <= underrun_d;
      // p1: amplitude aligned with the LUT read; p2: scaled sample to the DAC
      amp_p1_q     <= amp_p1_d;
      sample_p2_q  <= sample_p2_d;
    end
  end

  assign lut_addr   = phase_q[PHASE_W-1 -: LUT_AW];
  assign sample_out = sample_p2_q;
  assign sym_strobe = sym_strobe_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_mary_ask_modulator.sv
// Randomized scoreboard bench for mary_ask_modulator with a queue-based
// behavioural model of bit packing, symbol ticks and the output pipeline.
module tb_mary_ask_modulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_bps;
  logic [15:0] cfg_fcw;
  logic [15:0] cfg_sym_period;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [7:0]  sample_out;
  logic        sym_strobe;
  logic        underrun;

  logic [7:0]  lut_mem [256];
  int          vectors = 0;
  int          miscompares = 0;

  mary_ask_modulator #(
    .PHASE_W(16), .LUT_AW(8), .DATA_W(8), .SYM_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_bps(cfg_bps), .cfg_fcw(cfg_fcw),
    .cfg_sym_period(cfg_sym_period), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .lut_addr(lut_addr), .lut_data(lut_data),
    .sample_out(sample_out), .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // External sine LUT stand-in: one cycle of read latency.
  always @(posedge clk) lut_data <= lut_mem[lut_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int step_of(input int b);
    case (b)
      1:       return 255;
      2:       return 85;
      3:       return 36;
      default: return 0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int m_phase, m_cnt, m_mode, m_amp, m_sym;
  bit m_ready;
  bit m_bits[$];
  int st1_addr, st1_amp, st2_addr, st2_amp;
  int samp_q[$];
  bit tick_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_mode = 0; m_amp = 0; m_ready = 1'b0;
      st1_addr = 0; st1_amp = 0; st2_addr = 0; st2_amp = 0;
      m_bits.delete(); samp_q.delete(); tick_q.delete();
    end else begin
      if (bit_valid && m_ready) m_bits.push_back(bit_in);
      if (m_cnt == int'(cfg_sym_period)) begin
        m_cnt = 0;
        if (int'(cfg_bps) != m_mode) begin
          m_mode = int'(cfg_bps);
          m_bits.delete();
          m_amp = 0;
          tick_q.push_back(1'b0);
        end else if (m_mode != 0 && m_bits.size() == m_mode) begin
          m_sym = 0;
          foreach (m_bits[i]) m_sym = m_sym * 2 + int'(m_bits[i]);
          m_amp = m_sym * step_of(m_mode);
          m_bits.delete();
          tick_q.push_back(1'b0);
        end else begin
          m_amp = 0;
          tick_q.push_back(m_mode != 0);
        end
      end else begin
        m_cnt++;
      end
      m_phase = (m_phase + int'(cfg_fcw)) % 65536;
      samp_q.push_back((int'(lut_mem[st2_addr]) * st2_amp) / 256);
      st2_addr = st1_addr; st2_amp = st1_amp;
      st1_addr = m_phase / 256; st1_amp = m_amp;
      m_ready = (m_mode != 0) && (m_bits.size() < m_mode);
    end
  end

  // ---------------- monitor ----------------
  bit mon_exp_tick;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_exp_tick = (tick_q.size() != 0);
      if (samp_q.size() != 0) check("sample_out", 32'(sample_out), 32'(samp_q.pop_front()));
      check("bit_ready", 32'(bit_ready), 32'(m_ready));
      check("lut_addr", 32'(lut_addr), 32'(m_phase / 256));
      check("sym_strobe", 32'(sym_strobe), 32'(mon_exp_tick));
      check("underrun", 32'(underrun), mon_exp_tick ? 32'(tick_q.pop_front()) : 32'd0);
    end
  end

  // ---------------- bit source ----------------
  bit src_q[$];
  int valid_pct = 100;

  always @(posedge clk)
    if (rst === 1'b0 && bit_valid && bit_ready) void'(src_q.pop_front());

  always @(negedge clk) begin
    bit_valid = (src_q.size() != 0) && ($urandom_range(99) < valid_pct);
    bit_in    = (src_q.size() != 0) ? src_q[0] : 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic assert_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_sym_strobe", 32'(sym_strobe), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    src_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  int         kat_bps  [3] = '{1, 2, 3};
  logic [7:0] kat_lut  [3] = '{8'd128, 8'd200, 8'd255};
  int         kat_n    [3] = '{3, 2, 3};
  int         kat_bits [3] = '{5, 2, 7};
  int         kat_exp  [3][3] = '{'{127, 0, 127}, '{132, 0, 0}, '{251, 0, 0}};

  initial begin
    rst = 1'b1;
    cfg_bps = 2'd0;
    cfg_fcw = 16'd0;
    cfg_sym_period = 16'd0;
    for (int i = 0; i < 256; i++) lut_mem[i] = 8'($urandom_range(255));

    // Known-answer symbols: constant LUT, period 10 cycles, bits queued before the mode loads.
    for (int k = 0; k < 3; k++) begin
      assert_reset();
      for (int i = 0; i < 256; i++) lut_mem[i] = kat_lut[k];
      cfg_sym_period = 16'd9;
      cfg_fcw = 16'd4096;
      cfg_bps = 2'(kat_bps[k]);
      valid_pct = 100;
      for (int b = kat_n[k] - 1; b >= 0; b--) src_q.push_back(kat_bits[k][b]);
      release_reset();
      repeat (25) @(negedge clk);
      #1 check("kat_sym1", 32'(sample_out), 32'(kat_exp[k][0]));
      repeat (10) @(negedge clk);
      #1 check("kat_sym2", 32'(sample_out), 32'(kat_exp[k][1]));
      repeat (10) @(negedge clk);
      #1 check("kat_sym3", 32'(sample_out), 32'(kat_exp[k][2]));
    end

    // Half-rate carrier: lut_addr toggles between 0x00 and 0x80; then a starved symbol.
    assert_reset();
    for (int i = 0; i < 256; i++) lut_mem[i] = 8'($urandom_range(255));
    cfg_fcw = 16'h8000;
    cfg_sym_period = 16'd3;
    cfg_bps = 2'd2;
    for (int i = 0; i < 40; i++) src_q.push_back(1'($urandom_range(1)));
    release_reset();
    repeat (5) @(negedge clk);
    #1 check("fcw_half_odd", 32'(lut_addr), 32'h80);
    @(negedge clk);
    #1 check("fcw_half_even", 32'(lut_addr), 32'h00);
    repeat (10) @(negedge clk);
    valid_pct = 0;
    repeat (8) @(negedge clk);
    valid_pct = 100;
    repeat (20) @(negedge clk);

    // Randomized segments; each new segment resets the block mid-operation.
    for (int seg = 0; seg < 10; seg++) begin
      assert_reset();
      for (int i = 0; i < 256; i++) lut_mem[i] = 8'($urandom_range(255));
      cfg_sym_period = (seg % 4 == 3) ? 16'($urandom_range(20, 8)) : 16'($urandom_range(6));
      cfg_fcw = 16'($urandom);
      cfg_bps = 2'($urandom_range(3));
      valid_pct = $urandom_range(100, 30);
      for (int i = 0; i < 600; i++) src_q.push_back(1'($urandom_range(1)));
      release_reset();
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        if ($urandom_range(39) == 0) cfg_bps = 2'($urandom_range(3));
        if ($urandom_range(59) == 0) cfg_fcw = 16'($urandom);
        if ($urandom_range(29) == 0) valid_pct = $urandom_range(100);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mary_ask_modulator.md
# mary_ask_modulator

Parametrised M-ary ASK transmitter core: accepts a serial bit stream over a valid/ready handshake, packs 1–3 bits per symbol, and amplitude-keys a phase-accumulator carrier read from an external sine LUT. It replaces the fixed-rate 2/4/8-ASK path with a programmable carrier frequency, a programmable symbol rate, back-pressure on the bit source, and underrun reporting. It sits between the bit source (LFSR or host) and the DAC output stage.

## Interface
- PHASE_W, 16, phase accumulator width
- LUT_AW, 8, sine LUT address width; the LUT address is the phase MSBs
- DATA_W, 8, LUT sample width and output sample width
- SYM_W, 16, symbol period counter width
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- cfg_bps  in  2  bits per symbol: 0 = carrier off, 1/2/3 = 2/4/8-ASK
- cfg_fcw  in  PHASE_W  frequency control word, added to the phase every cycle
- cfg_sym_period  in  SYM_W  symbol length minus 1, in clk cycles
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  block accepts bit_in this cycle
- lut_addr  out  LUT_AW  sine LUT address; combinational from the phase register
- lut_data  in  DATA_W  unsigned LUT sample, valid 1 cycle after lut_addr
- sample_out  out  DATA_W  modulated sample to the DAC
- sym_strobe  out  1  one-cycle pulse on every symbol tick
- underrun  out  1  one-cycle pulse on a tick that found an incomplete bit buffer

## Operation
- **Phase:** `phase <= phase + cfg_fcw` every cycle, wrapping mod 2^PHASE_W. `lut_addr = phase[PHASE_W-1 -: LUT_AW]`. The phase runs in every state.
- **Symbol timer:** `sym_cnt` counts 0..cfg_sym_period. A tick occurs when `sym_cnt == cfg_sym_period`; `sym_cnt` then returns to 0. A symbol therefore lasts cfg_sym_period+1 cycles, and period 0 gives a tick every cycle.
- **Active mode:** `bps_act` is loaded from cfg_bps only on a tick. cfg_fcw and cfg_sym_period are used live.
- **FSM (states IDLE, FILL, FULL):**
  - IDLE: `bps_act == 0`. bit_ready=0, buffer cleared, symbol=0.
  - FILL: `bit_cnt < bps_act`. bit_ready=1. Each handshake (bit_valid & bit_ready) shifts bit_in into the buffer MSB-first and increments bit_cnt. Reaching bps_act moves the FSM to FULL.
  - FULL: bit_ready=0.
- **Tick behaviour:**
  - If the buffer is complete, including a bit accepted in the same cycle, `symbol <= buffer`, bit_cnt <= 0, and the FSM goes to FILL.
  - Else, if bps_act ≠ 0: symbol <= 0, underrun pulses, and the partial bits are retained.
  - If the newly loaded cfg_bps differs from bps_act: the buffer is flushed, symbol <= 0, underrun is not pulsed, and the next state follows the new mode.
- **Amplitude:**
  - `amp = symbol * STEP`, with STEP = 255 for bps 1, 85 for bps 2, 36 for bps 3. Full scale is 255, 255 and 252 respectively.
  - `sample_out <= (lut_data * amp_d) >> 8`, where the product is DATA_W+8 bits, the result is truncated, and `amp_d` is amp delayed 1 cycle to align with lut_data.
  - The output is 0 whenever bps_act == 0.

## Timing
- **Reset:** all registers async-cleared.
  - phase=0, sym_cnt=0, bps_act=0, bit_cnt=0, symbol=0.
  - FSM=IDLE.
  - Outputs: sample_out=0, bit_ready=0, sym_strobe=0, underrun=0, lut_addr=0.
- **Phase-to-output latency:** phase value at edge n → lut_data at n+1 → sample_out at n+2.
- **Symbol latency:** a symbol loaded at tick edge t affects sample_out from edge t+2.
- **sym_strobe:** registered, high for the cycle after the tick edge. underrun is aligned with sym_strobe.
- **Handshake:** bit_ready depends only on state, never combinationally on bit_valid. A bit is taken exactly on cycles where valid and ready are both high.
- **Reset mid-symbol:** the partial buffer is lost and the block restarts in IDLE. The first tick comes cfg_sym_period+1 cycles after reset release.

## Test plan
- cfg_bps=1, period=9, fcw=4096, LUT returns constant 128, bits 1,0,1 supplied early → sample_out follows 127,0,127 per 10-cycle symbol (first symbol after the first mode-load tick), with sym_strobe every 10 cycles.
- cfg_bps=2, LUT constant 200, bits 1,0 → symbol 2, amp 170, sample_out=132. cfg_bps=3, bits 1,1,1, LUT 255 → sample_out=251.
- bit_valid held low for one symbol in 2-ASK → underrun pulses once with sym_strobe, sample_out=0 for that symbol, and bit_ready stays high.
- Final bit of a full buffer delivered on the tick cycle → symbol loaded on that tick with no underrun.
- Switch cfg_bps 3→2 mid-symbol with a partial buffer → no change until the tick. At the tick, the buffer is flushed, symbol=0 and there is no underrun; subsequent symbols use 2 bits.
- fcw=0x8000 → lut_addr alternates 0x00/0x80 (phase wraps). Assert rst mid-FILL → all outputs 0 immediately, and recovery after release behaves per the reset timing above.
